// File: rtl/el2_pkg.sv
// Shared DCCM types: init FSM state encoding and index-width helper.
package el2_pkg;

    typedef enum logic [1:0] {
        INIT_IDLE = 2'b00,
        INIT_FILL = 2'b01,
        INIT_DONE = 2'b10
    } el2_dccm_init_state_e;

    // Index width for a bank of the given depth; never narrower than one bit.
    function automatic int DCCM_IDX_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/el2_dccm_bank.sv
// One DCCM bank: single-port {ecc,data} RAM with read-data/valid flops and
// an optional second output register.
module el2_dccm_bank
    import el2_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int W       = 39,
    parameter int RD_PIPE = 0
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         me_i,
    input  logic                         we_i,
    input  logic [DCCM_IDX_W(DEPTH)-1:0] addr_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 rdata_o,
    output logic                         rvalid_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_q;
    logic         rv_q;
    logic         rd_en;

    assign rd_en = me_i && !we_i;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (me_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_en;
            if (rd_en) begin
                rd_q <= mem_q[addr_i];
            end
        end
    end

    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic [W-1:0] pipe_q;
            logic         pv_q;

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    pipe_q <= '0;
                    pv_q   <= 1'b0;
                end else begin
                    pv_q <= rv_q;
                    if (rv_q) begin
                        pipe_q <= rd_q;
                    end
                end
            end

            assign rdata_o  = pipe_q;
            assign rvalid_o = pv_q;
        end else begin : g_nopipe
            assign rdata_o  = rd_q;
            assign rvalid_o = rv_q;
        end
    endgenerate

endmodule

// File: rtl/el2_dccm_bank_array.sv
// DCCM bank array with hardware zero-fill sequencer in front of the banks.
//   state     | meaning
//   INIT_IDLE | reset just released; decide whether to fill
//   INIT_FILL | writing zero codeword at cnt_q in every bank
//   INIT_DONE | functional access; init_req restarts the fill
module el2_dccm_bank_array
    import el2_pkg::*;
#(
    parameter int NUM_BANKS     = 4,
    parameter int DEPTH         = 2048,
    parameter int DATA_W        = 32,
    parameter int ECC_W         = 7,
    parameter int RD_PIPE       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_l,
    input  logic                                   scan_mode,
    input  logic                                   init_req,
    output logic                                   init_busy,
    output logic                                   init_done,
    input  logic [NUM_BANKS-1:0]                   bank_clken,
    input  logic [NUM_BANKS-1:0]                   bank_wren,
    input  logic [NUM_BANKS*DCCM_IDX_W(DEPTH)-1:0] bank_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]            bank_wr_data,
    input  logic [NUM_BANKS*ECC_W-1:0]             bank_wr_ecc,
    output logic [NUM_BANKS*DATA_W-1:0]            bank_rd_data,
    output logic [NUM_BANKS*ECC_W-1:0]             bank_rd_ecc,
    output logic [NUM_BANKS-1:0]                   bank_rd_valid,
    output logic                                   access_err
);

    localparam int IDX_W = DCCM_IDX_W(DEPTH);
    localparam int W     = DATA_W + ECC_W;
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

    el2_dccm_init_state_e state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 err_q;
    logic                 fill;

    assign fill = (state_q == INIT_FILL);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= INIT_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= fill && (|bank_clken);
        end
    end

    // scan_mode freezes state and counter exactly where they are.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (!scan_mode) begin
            case (state_q)
                INIT_IDLE: begin
                    if (INIT_ON_RESET != 0) begin
                        state_d = INIT_FILL;
                        cnt_d   = '0;
                    end else begin
                        state_d = INIT_DONE;
                    end
                end
                INIT_FILL: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = INIT_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
                INIT_DONE: begin
                    if (init_req) begin
                        state_d = INIT_FILL;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = INIT_IDLE;
            endcase
        end
    end

    assign init_busy  = fill;
    assign init_done  = done_q;
    assign access_err = err_q;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic             me, we;
            logic [IDX_W-1:0] addr;
            logic [W-1:0]     wdata, rdata;

            // Fill owns every bank; functional requests are dropped meanwhile.
            assign me    = fill ? 1'b1 : bank_clken[b];
            assign we    = fill ? 1'b1 : bank_wren[b];
            assign addr  = fill ? cnt_q : bank_addr[b*IDX_W +: IDX_W];
            assign wdata = fill ? '0 : {bank_wr_ecc[b*ECC_W +: ECC_W],
                                        bank_wr_data[b*DATA_W +: DATA_W]};

            el2_dccm_bank #(
                .DEPTH  (DEPTH),
                .W      (W),
                .RD_PIPE(RD_PIPE)
            ) u_bank (
                .clk     (clk),
                .rst_l   (rst_l),
                .me_i    (me),
                .we_i    (we),
                .addr_i  (addr),
                .wdata_i (wdata),
                .rdata_o (rdata),
                .rvalid_o(bank_rd_valid[b])
            );

            assign bank_rd_data[b*DATA_W +: DATA_W] = rdata[DATA_W-1:0];
            assign bank_rd_ecc[b*ECC_W +: ECC_W]    = rdata[W-1:DATA_W];
        end
    endgenerate

endmodule

// File: tb/tb_el2_dccm_bank_array.sv
// Scoreboard bench: stimulus pushes expected read results per bank, a monitor
// pops and compares whenever bank_rd_valid fires.
module tb_el2_dccm_bank_array;

    localparam int NB = 4;
    localparam int DEPTH = 16;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int RD_PIPE = 1;

    logic clk = 1'b0;
    logic rst_l;
    logic scan_mode;
    logic init_req;
    logic init_busy;
    logic init_done;
    logic [NB-1:0] bank_clken;
    logic [NB-1:0] bank_wren;
    logic [NB*IW-1:0] bank_addr;
    logic [NB*DW-1:0] bank_wr_data;
    logic [NB*EW-1:0] bank_wr_ecc;
    logic [NB*DW-1:0] bank_rd_data;
    logic [NB*EW-1:0] bank_rd_ecc;
    logic [NB-1:0] bank_rd_valid;
    logic access_err;

    el2_dccm_bank_array #(
        .NUM_BANKS(NB), .DEPTH(DEPTH), .DATA_W(DW), .ECC_W(EW),
        .RD_PIPE(RD_PIPE), .INIT_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .init_req(init_req),
        .init_busy(init_busy), .init_done(init_done),
        .bank_clken(bank_clken), .bank_wren(bank_wren), .bank_addr(bank_addr),
        .bank_wr_data(bank_wr_data), .bank_wr_ecc(bank_wr_ecc),
        .bank_rd_data(bank_rd_data), .bank_rd_ecc(bank_rd_ecc),
        .bank_rd_valid(bank_rd_valid), .access_err(access_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW+EW-1:0] val;
        int               cyc;
    } exp_t;

    exp_t             exp_q [NB][$];
    logic [DW+EW-1:0] mem_m [NB][DEPTH];
    logic [DW+EW-1:0] last_m [NB];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented read and checks outputs hold otherwise.
    always @(negedge clk) begin
        if (!rst_l) begin
            for (int b = 0; b < NB; b++) begin
                last_m[b] = '0;
                exp_q[b].delete();
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                logic [DW+EW-1:0] act;
                act = {bank_rd_ecc[b*EW +: EW], bank_rd_data[b*DW +: DW]};
                if (bank_rd_valid[b]) begin
                    if (exp_q[b].size() == 0) begin
                        chk($sformatf("unexpected_valid_b%0d", b), 64'(bank_rd_valid[b]), 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q[b].pop_front();
                        chk($sformatf("rd_val_b%0d", b), 64'(act), 64'(e.val));
                        chk($sformatf("rd_lat_b%0d", b), 64'(cyc), 64'(e.cyc));
                        last_m[b] = e.val;
                    end
                end else begin
                    chk($sformatf("rd_hold_b%0d", b), 64'(act), 64'(last_m[b]));
                end
            end
        end
    end

    task automatic idle_bus();
        bank_clken = '0;
        bank_wren  = '0;
        init_req   = 1'b0;
    endtask

    task automatic drive(input int b, input bit wr, input int a,
                         input logic [DW-1:0] d, input logic [EW-1:0] e);
        bank_clken[b] = 1'b1;
        bank_wren[b]  = wr;
        bank_addr[b*IW +: IW]   = IW'(a);
        bank_wr_data[b*DW +: DW] = d;
        bank_wr_ecc[b*EW +: EW]  = e;
        if (wr) mem_m[b][a] = {e, d};
        else exp_q[b].push_back('{val: mem_m[b][a], cyc: cyc + 1 + RD_PIPE});
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(negedge clk);
            idle_bus();
        end
        for (int b = 0; b < NB; b++) chk($sformatf("missing_reads_b%0d", b), 64'(exp_q[b].size()), 64'd0);
    endtask

    task automatic model_zero();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) mem_m[b][a] = '0;
    endtask

    // Counts busy cycles of one fill; optionally injects an access or an init_req.
    task automatic wait_fill(input int inj_at, input int req_at,
                             output int n, output int errs, output int dbad);
        n = 0; errs = 0; dbad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            idle_bus();
            if (access_err) errs++;
            if (init_busy && init_done) dbad++;
            if (init_busy) n++;
            else if (n > 0) break;
            if (n == inj_at) begin
                bank_clken[1] = 1'b1;
                bank_wren[1]  = 1'b1;
                bank_addr[1*IW +: IW] = '0;
                bank_wr_data[1*DW +: DW] = 32'h12345678;
                bank_wr_ecc[1*EW +: EW] = 7'h2A;
            end
            if (n == req_at) init_req = 1'b1;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            idle_bus();
            for (int b = 0; b < NB; b++) drive(b, 1'b0, a, '0, '0);
        end
        drain(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n, errs, dbad, busy_seen;
        rst_l = 1'b0; scan_mode = 1'b0; init_req = 1'b0;
        bank_clken = '0; bank_wren = '0; bank_addr = '0;
        bank_wr_data = '0; bank_wr_ecc = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(init_busy), 64'd0);
        chk("rst_done", 64'(init_done), 64'd0);
        chk("rst_valid", 64'(bank_rd_valid), 64'd0);
        chk("rst_err", 64'(access_err), 64'd0);
        chk("rst_rd_data", 64'(bank_rd_data[63:0]), 64'd0);
        rst_l = 1'b1;

        wait_fill(-1, -1, n, errs, dbad);
        chk("auto_fill_len", 64'(n), 64'(DEPTH));
        chk("auto_fill_done", 64'(init_done), 64'd1);
        chk("auto_fill_err", 64'(errs), 64'd0);
        model_zero();
        read_all();

        @(negedge clk); idle_bus();
        drive(2, 1'b1, 5, 32'hDEADBEEF, 7'h55);
        @(negedge clk); idle_bus();
        drive(2, 1'b0, 5, '0, '0);
        drain(4);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            idle_bus();
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 3) != 0)
                    drive(b, $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
                          $urandom, 7'($urandom));
        end
        drain(4);

        @(negedge clk); idle_bus();
        for (int b = 0; b < NB; b++) drive(b, 1'b1, 7, 32'hFFFFFFFF, 7'h7F);
        @(negedge clk); idle_bus();
        for (int b = 0; b < NB; b++) drive(b, 1'b0, 7, '0, '0);
        drain(4);
        init_req = 1'b1;
        wait_fill(8, -1, n, errs, dbad);
        chk("req_fill_len", 64'(n), 64'(DEPTH));
        chk("req_fill_err_pulses", 64'(errs), 64'd1);
        chk("req_fill_done_clr", 64'(dbad), 64'd0);
        chk("req_fill_done", 64'(init_done), 64'd1);
        model_zero();
        read_all();

        @(negedge clk); idle_bus();
        init_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            @(negedge clk);
            idle_bus();
            if (init_busy) n++;
        end
        #2 rst_l = 1'b0;
        #1;
        chk("midrst_busy", 64'(init_busy), 64'd0);
        chk("midrst_done", 64'(init_done), 64'd0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        wait_fill(-1, -1, n, errs, dbad);
        chk("midrst_fill_len", 64'(n), 64'(DEPTH));
        chk("midrst_fill_done", 64'(init_done), 64'd1);
        read_all();

        @(negedge clk); idle_bus();
        init_req = 1'b1;
        wait_fill(-1, 5, n, errs, dbad);
        chk("ignreq_fill_len", 64'(n), 64'(DEPTH));
        chk("ignreq_fill_done", 64'(init_done), 64'd1);
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (init_busy) busy_seen++;
        end
        chk("ignreq_no_refill", 64'(busy_seen), 64'd0);

        scan_mode = 1'b1;
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (init_busy) busy_seen++;
        end
        scan_mode = 1'b0;
        chk("scan_freeze_busy", 64'(busy_seen), 64'd0);
        chk("scan_freeze_done", 64'(init_done), 64'd1);

        drain(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
